// File: rtl/tree_lane_dispatcher.sv
// Dual-lane issue front-end: buffers packet headers in a FIFO and issues up to two per
// cycle (oldest on lane 1), tagged with the root node latched while idle.
module tree_lane_dispatcher #(
  parameter int PACKET_WIDTH = 104,
  parameter int NODE_WIDTH   = 40,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          RSTn,
  input  logic                          enable,
  input  logic                          hold,
  input  logic [NODE_WIDTH-1:0]         cfg_root_node,
  input  logic [PACKET_WIDTH-1:0]       in_packet,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [PACKET_WIDTH-1:0]       packet_out1,
  output logic [PACKET_WIDTH-1:0]       packet_out2,
  output logic                          data_valid_out1,
  output logic                          data_valid_out2,
  output logic [NODE_WIDTH-1:0]         node_out1,
  output logic [NODE_WIDTH-1:0]         node_out2,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          issued_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NODE_WIDTH-1:0]   root_q, root_d;
  logic [PACKET_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PACKET_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [PACKET_WIDTH-1:0] pkt1_q, pkt1_d, pkt2_q, pkt2_d;
  logic                    vld1_q, vld1_d, vld2_q, vld2_d;
  logic [NODE_WIDTH-1:0]   node1_q, node1_d, node2_q, node2_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic                    push_s;
  logic [1:0]              n_s;
  logic [PTR_W-1:0]        rd_ptr_nxt_s;

  // Ready depends only on registered state so there is no in_valid -> in_ready path.
  assign in_ready        = (state_q == S_RUN) && (level_q < LVL_W'(FIFO_DEPTH));
  assign busy            = (state_q != S_IDLE);
  assign fifo_level      = level_q;
  assign issued_cnt      = cnt_q;
  assign packet_out1     = pkt1_q;
  assign packet_out2     = pkt2_q;
  assign data_valid_out1 = vld1_q;
  assign data_valid_out2 = vld2_q;
  assign node_out1       = node1_q;
  assign node_out2       = node2_q;

  // Issue count, FIFO bookkeeping, lane data and counter update.
  always_comb begin
    push_s       = in_valid && in_ready;
    rd_ptr_nxt_s = rd_ptr_q + PTR_W'(1);
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pkt1_d       = '0;
    pkt2_d       = '0;
    vld1_d       = 1'b0;
    vld2_d       = 1'b0;
    node1_d      = '0;
    node2_d      = '0;

    if ((state_q != S_IDLE) && !hold) begin
      if (level_q >= LVL_W'(2)) begin
        n_s = 2'd2;
      end else begin
        n_s = level_q[1:0];
      end
    end else begin
      n_s = 2'd0;
    end

    if (push_s) begin
      mem_d[wr_ptr_q] = in_packet;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (n_s != 2'd0) begin
      vld1_d   = 1'b1;
      pkt1_d   = mem_q[rd_ptr_q];
      node1_d  = root_q;
      rd_ptr_d = rd_ptr_nxt_s;
    end else begin
      vld1_d = 1'b0;
    end

    // Second entry read through the incremented pointer so a pair straddling the wrap is ordered.
    if (n_s == 2'd2) begin
      vld2_d   = 1'b1;
      pkt2_d   = mem_q[rd_ptr_nxt_s];
      node2_d  = root_q;
      rd_ptr_d = rd_ptr_q + PTR_W'(2);
    end else begin
      vld2_d = 1'b0;
    end

    level_d = level_q + LVL_W'(push_s) - LVL_W'(n_s);
    cnt_d   = cnt_q + CNT_WIDTH'(n_s);
  end

  // Run/drain/idle sequencing and root latching.
  always_comb begin
    state_d = state_q;
    root_d  = root_q;
    case (state_q)
      S_IDLE: begin
        root_d = cfg_root_node;
        if (enable) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!enable) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (level_d == '0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, FIFO and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= S_IDLE;
      root_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pkt1_q   <= '0;
      pkt2_q   <= '0;
      vld1_q   <= 1'b0;
      vld2_q   <= 1'b0;
      node1_q  <= '0;
      node2_q  <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      root_q   <= root_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pkt1_q   <= pkt1_d;
      pkt2_q   <= pkt2_d;
      vld1_q   <= vld1_d;
      vld2_q   <= vld2_d;
      node1_q  <= node1_d;
      node2_q  <= node2_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_tree_lane_dispatcher.sv
// Scoreboard bench: stimulus feeds a queue-based reference model; a monitor checks lane issues.
module tb_tree_lane_dispatcher;
  localparam int PW = 104;
  localparam int NW = 40;
  localparam int D  = 8;
  localparam int CW = 32;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          hold = 1'b0;
  logic          in_valid = 1'b0;
  logic [NW-1:0] cfg_root = '0;
  logic [PW-1:0] in_packet = '0;

  logic          in_ready, dv1, dv2, busy;
  logic [PW-1:0] p1, p2;
  logic [NW-1:0] n1, n2;
  logic [LW-1:0] level;
  logic [CW-1:0] cnt;

  logic          in_ready_4, dv1_4, dv2_4, busy_4;
  logic [PW-1:0] p1_4, p2_4;
  logic [NW-1:0] n1_4, n2_4;
  logic [LW-1:0] level_4;
  logic [3:0]    cnt_4;

  tree_lane_dispatcher #(.PACKET_WIDTH(PW), .NODE_WIDTH(NW), .FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .RSTn(rst_n), .enable(enable), .hold(hold), .cfg_root_node(cfg_root),
    .in_packet(in_packet), .in_valid(in_valid), .in_ready(in_ready),
    .packet_out1(p1), .packet_out2(p2), .data_valid_out1(dv1), .data_valid_out2(dv2),
    .node_out1(n1), .node_out2(n2), .busy(busy), .fifo_level(level), .issued_cnt(cnt));

  tree_lane_dispatcher #(.PACKET_WIDTH(PW), .NODE_WIDTH(NW), .FIFO_DEPTH(D), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .RSTn(rst_n), .enable(enable), .hold(hold), .cfg_root_node(cfg_root),
    .in_packet(in_packet), .in_valid(in_valid), .in_ready(in_ready_4),
    .packet_out1(p1_4), .packet_out2(p2_4), .data_valid_out1(dv1_4), .data_valid_out2(dv2_4),
    .node_out1(n1_4), .node_out2(n2_4), .busy(busy_4), .fifo_level(level_4), .issued_cnt(cnt_4));

  always #5 clk = ~clk;

  typedef struct {
    logic          v2;
    logic [PW-1:0] pa;
    logic [PW-1:0] pb;
    logic [NW-1:0] node;
    longint        cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [PW-1:0] mq[$];
  int            mode;          // 0 idle, 1 run, 2 drain
  logic [NW-1:0] mroot;
  logic [63:0]   mcnt;
  longint        cyc = 0;
  int            compared = 0;
  int            mismatched = 0;
  exp_t          me;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [PW-1:0] rand_pkt();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[PW-1:0];
  endfunction

  // Monitor: compares every lane output against the scoreboard after each edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst_n) begin
      if (dv1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 128'(dv1), 128'(0));
        end else begin
          me = exp_q.pop_front();
          chk("issue_cycle", 128'(cyc), 128'(me.cyc));
          chk("lane1_pkt", 128'(p1), 128'(me.pa));
          chk("lane1_node", 128'(n1), 128'(me.node));
          chk("lane2_valid", 128'(dv2), 128'(me.v2));
          chk("lane2_pkt", 128'(p2), 128'(me.pb));
          chk("lane2_node", 128'(n2), me.v2 ? 128'(me.node) : 128'(0));
        end
      end else begin
        chk("idle_lanes_zero", 128'({dv2, |p1, |p2, |n1, |n2}), 128'(0));
      end
    end
  end

  // One cycle: check registered state, drive inputs, advance the reference model.
  task automatic step(input logic en, input logic h, input logic v,
                      input logic [PW-1:0] pkt, input logic [NW-1:0] cfg);
    int   n;
    bit   rdy;
    exp_t e;
    chk("fifo_level", 128'(level), 128'(mq.size()));
    chk("busy", 128'(busy), 128'(mode != 0));
    chk("issued_cnt", 128'(cnt), 128'(mcnt[31:0]));
    chk("issued_cnt_w4", 128'(cnt_4), 128'(mcnt[3:0]));
    enable = en; hold = h; in_valid = v; in_packet = pkt; cfg_root = cfg;
    #1;
    rdy = (mode == 1) && (mq.size() < D);
    chk("in_ready", 128'(in_ready), 128'(rdy));
    n = (mode != 0 && !h) ? ((mq.size() < 2) ? mq.size() : 2) : 0;
    if (n > 0) begin
      e.v2   = (n == 2);
      e.pa   = mq.pop_front();
      e.pb   = (n == 2) ? mq.pop_front() : '0;
      e.node = mroot;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    if (v && rdy) mq.push_back(pkt);
    mcnt = mcnt + 64'(n);
    case (mode)
      0: begin mroot = cfg; if (en) mode = 1; end
      1: if (!en) mode = 2;
      2: if (mq.size() == 0) mode = 0;
      default: mode = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic model_reset();
    mq.delete(); exp_q.delete();
    mode = 0; mroot = '0; mcnt = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_lanes"}, 128'({dv1, dv2, |p1, |p2, |n1, |n2}), 128'(0));
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_level"}, 128'(level), 128'(0));
    chk({tag, "_cnt"}, 128'(cnt), 128'(0));
  endtask

  // Reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain_to_idle();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, '0, 40'h12);
  endtask

  initial begin
    logic [PW-1:0] pa, pb, pc, px;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Stream A,B,C under hold so A,B pair, then C alone.
    pa = rand_pkt(); pb = rand_pkt(); pc = rand_pkt();
    step(1'b1, 1'b0, 1'b0, '0, 40'h12);
    step(1'b1, 1'b1, 1'b1, pa, 40'h0);
    step(1'b1, 1'b1, 1'b1, pb, 40'h0);
    step(1'b1, 1'b1, 1'b1, pc, 40'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, 40'h0);
    drain_to_idle();

    // Fill past depth under hold, then release with P8 still offered.
    step(1'b1, 1'b0, 1'b0, '0, 40'h77);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, rand_pkt(), 40'h0);
    px = rand_pkt();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, px, 40'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, px, 40'h0);
    step(1'b1, 1'b0, 1'b0, '0, 40'h0);
    drain_to_idle();

    // Drain from level 5 with enable toggling and changing cfg_root.
    step(1'b1, 1'b0, 1'b0, '0, 40'h5A);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, rand_pkt(), 40'h0);
    for (int i = 0; i < 6; i++) step(1'($urandom_range(1)), 1'b0, 1'b0, '0, 40'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 40'($urandom));

    // Async reset with level 6, then X must be the first output.
    step(1'b1, 1'b0, 1'b0, '0, 40'h33);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, rand_pkt(), 40'h0);
    async_reset();
    px = rand_pkt();
    step(1'b1, 1'b0, 1'b0, '0, 40'h44);
    step(1'b1, 1'b0, 1'b1, px, 40'h0);
    step(1'b1, 1'b0, 1'b0, '0, 40'h0);
    step(1'b1, 1'b0, 1'b0, '0, 40'h0);
    drain_to_idle();

    // Randomized phases with varying valid/hold/enable bias.
    for (int ph = 0; ph < 6; ph++) begin
      int pv, phl, pen;
      pv  = 30 + 15 * ph;
      phl = (ph % 3) * 30;
      pen = (ph == 2) ? 60 : 92;
      for (int i = 0; i < 400; i++) begin
        step(1'($urandom_range(99) < pen), 1'($urandom_range(99) < phl),
             1'($urandom_range(99) < pv), rand_pkt(), 40'($urandom));
      end
    end
    drain_to_idle();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
